conv_sched_ctrl: RTL and testbench

- Hardware sequencer for the CONV_256PE array; replaces software-side tile/channel/pixel sequencing with a parametrised on-chip scheduler.
- Walks the loop nest OFM channel > tile > IFM channel > kernel pixel.
- Drives read addresses for the IFM (im2col) buffer and the broadcast weight buffer, and drives PE accumulator clear/enable.
- Hands each finished tile result downstream over a valid/ready handshake, with issue-side stall support.

---
 rtl/conv_sched_ctrl_pkg.sv | 32 +++
 rtl/conv_sched_ctrl_delay_line.sv | 28 ++
 rtl/conv_sched_ctrl.sv | 153 +++++++++++++++
 tb/tb_conv_sched_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_ctrl_pkg.sv
// Shared state encoding and derived-constant helpers for the convolution scheduler.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

  // Kernel pixels per channel plane
  function automatic int k2_of(input int kernel_w);
    return kernel_w * kernel_w;
  endfunction

  // Beats accumulated into one output tile
  function automatic int group_len(input int kernel_w, input int ifm_c);
    return k2_of(kernel_w) * ifm_c;
  endfunction

  // Results produced by one layer pass
  function automatic int total_groups(input int ofm_c, input int num_tiles);
    return ofm_c * num_tiles;
  endfunction

  // im2col buffer distance between consecutive input channels
  function automatic logic [31:0] ifm_ch_stride(input int num_tiles, input int num_of_pe,
                                                input int k2);
    return 32'(num_tiles * num_of_pe * k2);
  endfunction

  // im2col buffer distance between consecutive tiles of one channel
  function automatic logic [31:0] ifm_tile_stride(input int num_of_pe, input int k2);
    return 32'(num_of_pe * k2);
  endfunction

endpackage

// File: rtl/conv_sched_ctrl_delay_line.sv
// Fixed-depth shift register aligning issue-side flags with data arriving at the PEs.
module sched_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // Shift one stage per cycle; never stalls so beats keep their spacing
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Stage registers, cleared on reset so no stale beat reaches the PEs
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_sched_ctrl.sv
// Loop-nest sequencer: oc > tile > ifm channel > kernel pixel, one group per output tile.
module conv_sched_ctrl #(
  parameter int NUM_OF_PE = 256,
  parameter int KERNEL_W  = 3,
  parameter int IFM_C     = 3,
  parameter int OFM_C     = 3,
  parameter int NUM_TILES = 4,
  parameter int RD_LAT    = 1,
  parameter int PE_LAT    = 1,
  parameter int IFM_AW    = 16,
  parameter int W_AW      = 10,
  localparam int OC_W = (OFM_C > 1) ? $clog2(OFM_C) : 1,
  localparam int TL_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              issue_stall,
  input  logic              ofm_ready,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_rd_addr,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_rd_addr,
  output logic              pe_restart,
  output logic              pe_acc_en,
  output logic              ofm_valid,
  output logic [OC_W-1:0]   ofm_oc,
  output logic [TL_W-1:0]   ofm_tile
);
  import conv_pkg::*;

  localparam int K2        = k2_of(KERNEL_W);
  localparam int G         = group_len(KERNEL_W, IFM_C);
  localparam int PX_W      = (K2 > 1) ? $clog2(K2) : 1;
  localparam int CH_W      = (IFM_C > 1) ? $clog2(IFM_C) : 1;
  localparam int DRAIN_CYC = RD_LAT + PE_LAT;
  localparam int DC_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [31:0] CH_STRIDE  = ifm_ch_stride(NUM_TILES, NUM_OF_PE, K2);
  localparam logic [31:0] TL_STRIDE  = ifm_tile_stride(NUM_OF_PE, K2);
  localparam logic [31:0] OC_WSTRIDE = 32'(G);
  localparam logic [31:0] CH_WSTRIDE = 32'(K2);

  state_e          state_q, state_d;
  logic [PX_W-1:0] px_q, px_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [TL_W-1:0] tile_q, tile_d;
  logic [OC_W-1:0] oc_q, oc_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic            done_q, done_d;
  logic            issue;
  logic [1:0]      pe_in, pe_out;

  // Next state and loop counters; tile/oc only advance on the result handshake
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    ch_d    = ch_q;
    tile_d  = tile_q;
    oc_d    = oc_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: if (!issue_stall) begin
        issue = 1'b1;
        if (px_q == PX_W'(K2 - 1)) begin
          px_d = '0;
          if (ch_q == CH_W'(IFM_C - 1)) begin
            ch_d    = '0;
            state_d = DRAIN;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          px_d = px_q + PX_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DC_W'(DRAIN_CYC - 1)) begin
          dcnt_d  = '0;
          state_d = OUT;
        end else begin
          dcnt_d = dcnt_q + DC_W'(1);
        end
      end
      OUT: if (ofm_ready) begin
        state_d = ISSUE;
        if (tile_q == TL_W'(NUM_TILES - 1)) begin
          tile_d = '0;
          if (oc_q == OC_W'(OFM_C - 1)) begin
            oc_d    = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            oc_d = oc_q + OC_W'(1);
          end
        end else begin
          tile_d = tile_q + TL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      ch_q    <= '0;
      tile_q  <= '0;
      oc_q    <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      ch_q    <= ch_d;
      tile_q  <= tile_d;
      oc_q    <= oc_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
    end
  end

  // Read strobes and addresses come straight from the counters, so they hold during a stall
  always_comb begin
    ifm_rd_en   = issue;
    w_rd_en     = issue;
    ifm_rd_addr = IFM_AW'(CH_STRIDE * 32'(ch_q) + TL_STRIDE * 32'(tile_q) + 32'(px_q));
    w_rd_addr   = W_AW'(OC_WSTRIDE * 32'(oc_q) + CH_WSTRIDE * 32'(ch_q) + 32'(px_q));
    busy        = (state_q != IDLE);
    done        = done_q;
    ofm_valid   = (state_q == OUT);
    ofm_oc      = oc_q;
    ofm_tile    = tile_q;
    pe_in       = {issue && (px_q == '0) && (ch_q == '0), issue};
  end

  sched_delay_line #(.DEPTH(RD_LAT), .WIDTH(2)) u_pe_align (
    .clk  (clk),
    .rst  (rst),
    .din  (pe_in),
    .dout (pe_out)
  );

  assign pe_restart = pe_out[1];
  assign pe_acc_en  = pe_out[0];

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Randomized bench for conv_sched_ctrl against a beat-level reference model.
module tb_conv_sched_ctrl;

  localparam int NPE = 256, KW = 3, IC = 3, OC = 3, NT = 4, RL = 1, PL = 1;
  localparam int K2 = KW * KW, G = K2 * IC, NG = OC * NT;

  logic clk = 1'b0;
  logic rst, start, issue_stall, ofm_ready;
  logic busy, done, ifm_rd_en, w_rd_en, pe_restart, pe_acc_en, ofm_valid;
  logic [15:0] ifm_rd_addr;
  logic [9:0]  w_rd_addr;
  logic [1:0]  ofm_oc, ofm_tile;

  logic s_start, s_stall, s_ready;
  logic s_busy, s_done, s_rd_en, s_w_rd_en, s_pe_restart, s_pe_acc_en, s_ofm_valid;
  logic [15:0] s_ifm_rd_addr;
  logic [9:0]  s_w_rd_addr;
  logic [1:0]  s_ofm_oc, s_ofm_tile;

  always #5 clk = ~clk;

  conv_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .issue_stall(issue_stall), .ofm_ready(ofm_ready),
    .busy(busy), .done(done), .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .pe_restart(pe_restart), .pe_acc_en(pe_acc_en),
    .ofm_valid(ofm_valid), .ofm_oc(ofm_oc), .ofm_tile(ofm_tile)
  );

  conv_sched_ctrl #(.RD_LAT(3), .KERNEL_W(1), .IFM_C(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .issue_stall(s_stall), .ofm_ready(s_ready),
    .busy(s_busy), .done(s_done), .ifm_rd_en(s_rd_en), .ifm_rd_addr(s_ifm_rd_addr),
    .w_rd_en(s_w_rd_en), .w_rd_addr(s_w_rd_addr), .pe_restart(s_pe_restart),
    .pe_acc_en(s_pe_acc_en), .ofm_valid(s_ofm_valid), .ofm_oc(s_ofm_oc), .ofm_tile(s_ofm_tile)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference addresses for the b-th beat of a pass, straight from the loop nest
  function automatic logic [31:0] exp_ifm(input int b);
    int g, r;
    g = b / G; r = b % G;
    return 32'(((r / K2) * NT * NPE * K2 + (g % NT) * NPE * K2 + (r % K2)) % 65536);
  endfunction

  function automatic logic [31:0] exp_w(input int b);
    int g, r;
    g = b / G; r = b % G;
    return 32'(((g / NT) * G + (r / K2) * K2 + (r % K2)) % 1024);
  endfunction

  // Monitor state
  int cyc = 100, beat = 0, grp = 0, acc_cnt = 0, rs_cnt = 0, done_cnt = 0, last_rd = 0;
  int arm_req = 0, arm_ack = 0;
  bit mon_on = 1'b0, prev_valid = 1'b0, hs_pend = 1'b0;
  bit rd_h[16], fb_h[16];
  logic [1:0] lat_oc, lat_tile;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mon_on) begin
      if (arm_req != arm_ack) begin
        arm_ack = arm_req; beat = 0; grp = 0; acc_cnt = 0; rs_cnt = 0;
        prev_valid = 1'b0; hs_pend = 1'b0;
        for (int i = 0; i < 16; i++) begin rd_h[i] = 1'b0; fb_h[i] = 1'b0; end
      end
      cyc++;
      rd_h[cyc % 16] = (ifm_rd_en === 1'b1);
      fb_h[cyc % 16] = (ifm_rd_en === 1'b1) && (beat % G == 0);
      if (hs_pend) begin
        hs_pend = 1'b0;
        chk("valid_after_hs", 32'(ofm_valid), 0);
        if (grp == NG) begin
          chk("done_pulse", 32'(done), 1);
          chk("busy_drop", 32'(busy), 0);
        end else begin
          chk("done_early", 32'(done), 0);
          chk("issue_after_hs", 32'(ifm_rd_en), 32'(!issue_stall));
        end
      end
      if (busy && issue_stall) chk("stall_blocks_rd", 32'(ifm_rd_en), 0);
      if (ifm_rd_en) begin
        chk("w_rd_en", 32'(w_rd_en), 1);
        chk("busy_in_issue", 32'(busy), 1);
        chk("no_issue_while_valid", 32'(ofm_valid), 0);
        if (beat < NG * G) begin
          chk("ifm_rd_addr", 32'(ifm_rd_addr), exp_ifm(beat));
          chk("w_rd_addr", 32'(w_rd_addr), exp_w(beat));
          if (beat == 6 * G + 2 * K2 + 4) begin
            chk("ifm_addr_oc1_t2", 32'(ifm_rd_addr), 23044);
            chk("w_addr_oc1_t2", 32'(w_rd_addr), 49);
          end
        end else begin
          chk("extra_beat", 32'(beat), NG * G - 1);
        end
        beat++;
        last_rd = cyc;
      end
      if (pe_acc_en || rd_h[(cyc - RL) % 16])
        chk("pe_acc_en", 32'(pe_acc_en), 32'(rd_h[(cyc - RL) % 16]));
      if (pe_restart || fb_h[(cyc - RL) % 16])
        chk("pe_restart", 32'(pe_restart), 32'(fb_h[(cyc - RL) % 16]));
      if (pe_acc_en) acc_cnt++;
      if (pe_restart) rs_cnt++;
      if (ofm_valid && !prev_valid) begin
        chk("group_beats", 32'(beat), 32'((grp + 1) * G));
        chk("acc_beats", 32'(acc_cnt), G);
        chk("restart_once", 32'(rs_cnt), 1);
        chk("valid_latency", 32'(cyc - last_rd), RL + PL + 1);
        chk("ofm_oc", 32'(ofm_oc), 32'(grp / NT));
        chk("ofm_tile", 32'(ofm_tile), 32'(grp % NT));
        acc_cnt = 0; rs_cnt = 0;
        lat_oc = ofm_oc; lat_tile = ofm_tile;
      end else if (ofm_valid) begin
        chk("oc_stable", 32'(ofm_oc), 32'(lat_oc));
        chk("tile_stable", 32'(ofm_tile), 32'(lat_tile));
      end
      if (ofm_valid && ofm_ready) begin hs_pend = 1'b1; grp++; end
      prev_valid = ofm_valid;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'({ifm_rd_addr, w_rd_addr}), 0);
    chk({tag, "_flags"}, 32'({busy, done, ifm_rd_en, w_rd_en, pe_restart, pe_acc_en,
                             ofm_valid, ofm_oc, ofm_tile}), 0);
  endtask

  // mode 0: clean; 1: random stall/ready/start; 2: directed 5-cycle stall and 10-cycle ready hold
  task automatic run_pass(input int mode);
    int d0, n, su, rl;
    d0 = done_cnt; su = 0; rl = 0; n = 0;
    issue_stall = 1'b0; ofm_ready = 1'b1;
    arm_req++; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("first_beat", 32'(ifm_rd_en), 1);
    chk("busy_on", 32'(busy), 1);
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk); #1; n++;
      case (mode)
        1: begin
          issue_stall = ($urandom_range(0, 3) == 0);
          ofm_ready   = ($urandom_range(0, 2) != 0);
          start       = (grp < NG - 1) && ($urandom_range(0, 7) == 0);
        end
        2: begin
          issue_stall = (beat >= 40) && (su < 5);
          if (issue_stall) su++;
          ofm_ready = !(ofm_valid && grp == 1 && rl < 10);
          if (!ofm_ready) rl++;
        end
        default: begin issue_stall = 1'b0; ofm_ready = 1'b1; end
      endcase
    end
    start = 1'b0; issue_stall = 1'b0; ofm_ready = 1'b0;
    chk("pass_timeout", 32'(n), 32'(n < 3000 ? n : 0));
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("results", 32'(grp), NG);
    chk("beats", 32'(beat), NG * G);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    rst = 1'b1; start = 1'b1; issue_stall = 1'b0; ofm_ready = 1'b0;
    s_start = 1'b1; s_stall = 1'b0; s_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; s_start = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    chk("s_reset_flags", 32'({s_busy, s_done, s_rd_en, s_pe_acc_en, s_ofm_valid}), 0);
    @(negedge clk);
    chk("start_under_rst", 32'(busy), 0);
    mon_on = 1'b1;

    run_pass(0);
    run_pass(2);
    run_pass(1);
    run_pass(1);

    // Abort in the DRAIN that follows the last beat of group 5
    @(posedge clk); #1;
    arm_req++; issue_stall = 1'b0; ofm_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (beat < 6 * G && n < 1000) begin @(posedge clk); #1; n++; end
    chk("reach_group5", 32'(beat), 6 * G);
    d0 = done_cnt; rst = 1'b1; mon_on = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    repeat (5) @(negedge clk);
    chk("no_done_on_abort", 32'(done_cnt), 32'(d0));
    mon_on = 1'b1;
    run_pass(1);

    // Short-group configuration: one beat per group, three-cycle read latency
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int g = 0; g < NG; g++) begin
      int k;
      k = 0;
      @(negedge clk);
      while (!s_rd_en && k < 20) begin @(negedge clk); k++; end
      chk("s_issue_gap", 32'(k), 0);
      chk("s_w_rd_en", 32'(s_w_rd_en), 1);
      chk("s_ifm_addr", 32'(s_ifm_rd_addr), 32'((g % NT) * NPE));
      chk("s_w_addr", 32'(s_w_rd_addr), 32'(g / NT));
      for (int d = 1; d <= 5; d++) begin
        @(negedge clk);
        chk("s_acc_en", 32'(s_pe_acc_en), 32'(d == 3));
        chk("s_restart", 32'(s_pe_restart), 32'(d == 3));
        chk("s_valid", 32'(s_ofm_valid), 32'(d == 5));
        chk("s_rd_idle", 32'(s_rd_en), 0);
      end
      chk("s_oc", 32'(s_ofm_oc), 32'(g / NT));
      chk("s_tile", 32'(s_ofm_tile), 32'(g % NT));
    end
    @(negedge clk);
    chk("s_done", 32'(s_done), 1);
    chk("s_busy_end", 32'(s_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
